// File: rtl/bit_iter.sv
// Sequential set-bit iterator: accepts a W-bit mask and a start position and
// emits the index of each set bit, ascending from the start with wrap-around.
module bit_iter #(
    parameter int W = 32,
    localparam int IW = $clog2(W)
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          in_vld_i,
    output logic          in_rdy_o,
    input  logic [W-1:0]  in_x_i,
    input  logic [IW-1:0] in_pos_i,
    output logic          out_vld_o,
    input  logic          out_rdy_i,
    output logic [IW-1:0] out_idx_o,
    output logic          out_last_o,
    output logic          empty_o,
    input  logic          abort_i,
    output logic          busy_o
);

    typedef enum logic {IDLE, RUN} state_e;

    state_e        st_q, st_d;
    logic [W-1:0]  mask_q, mask_d;
    logic [IW-1:0] pos_q, pos_d;
    logic          empty_q, empty_d;

    logic [W-1:0]  rot;
    logic [IW-1:0] rot_idx;
    logic [IW-1:0] hit_idx;
    logic          run;
    logic          last;

    assign run = (st_q == RUN);

    // Rotate so that bit pos_q lands at position 0; the lowest set bit of the
    // rotated mask is then the first hit of the cyclic scan.
    always_comb begin
        rot = '0;
        for (int i = 0; i < W; i++) begin
            rot[i] = mask_q[IW'(i) + pos_q];
        end
    end

    always_comb begin
        rot_idx = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (rot[i]) rot_idx = IW'(i);
        end
    end

    assign hit_idx = rot_idx + pos_q;
    // RUN guarantees a non-zero mask, so "no bit left after clearing the
    // lowest one" is the same as popcount == 1.
    assign last    = run && ((mask_q & (mask_q - W'(1))) == '0);

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves
        // it unassigned, which would otherwise infer a latch.
        st_d    = st_q;
        mask_d  = mask_q;
        pos_d   = pos_q;
        empty_d = 1'b0;
        case (st_q)
            IDLE: begin
                if (in_vld_i && !abort_i) begin
                    if (in_x_i != '0) begin
                        mask_d = in_x_i;
                        pos_d  = in_pos_i;
                        st_d   = RUN;
                    end else begin
                        empty_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (out_rdy_i) begin
                    mask_d = mask_q & ~(W'(1) << hit_idx);
                    pos_d  = hit_idx + IW'(1);
                    if (last) st_d = IDLE;
                end
                if (abort_i) begin
                    mask_d = '0;
                    st_d   = IDLE;
                end
            end
            default: st_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled at the same edge.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            st_q    <= IDLE;
            mask_q  <= '0;
            pos_q   <= '0;
            empty_q <= 1'b0;
        end else begin
            st_q    <= st_d;
            mask_q  <= mask_d;
            pos_q   <= pos_d;
            empty_q <= empty_d;
        end
    end

    assign in_rdy_o   = (st_q == IDLE);
    assign busy_o     = run;
    assign out_vld_o  = run;
    assign out_idx_o  = run ? hit_idx : '0;
    assign out_last_o = last;
    assign empty_o    = empty_q;

endmodule
